// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared UART clocking constants, arbiter state encoding and helpers
package uart_ctrl_pkg;
    localparam int FREQ = 27000000;
    localparam int BAUD = 115200;
    localparam int CLKS = FREQ / BAUD;
    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GAP} arb_state_t;
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin priority encoder starting after the last winner
module rr_picker #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    logic [IW-1:0] j;
    // scan from farthest to nearest so the nearest set bit after last_i overrides
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j = '0;
        for (int k = N; k >= 1; k--) begin
            j = IW'((int'(last_i) + k) % N);
            if (req_i[j]) begin
                gnt_o = '0;
                gnt_o[j] = 1'b1;
                idx_o = j;
            end
        end
    end
    assign any_o = |req_i;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART serializer with busy tracking and inter-frame gap
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int GAP_CLKS = 0,
    parameter int BUSY_TMO = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [N_REQ*DATA_W-1:0]    req_data_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic [DATA_W-1:0]          tx_data_o,
    output logic                       tx_start_o,
    input  logic                       tx_busy_i,
    output logic [$clog2(N_REQ)-1:0]   grant_id_o,
    output logic                       active_o,
    output logic                       err_tmo_o
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(max2(max2(GAP_CLKS, BUSY_TMO), 1) + 1);

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     last_q, last_d, grant_id_q, grant_id_d, win;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d, err_q, err_d, any;
    logic [N_REQ-1:0]  gnt;

    rr_picker #(.N(N_REQ)) u_pick (
        .req_i  (req_valid_i),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (win),
        .any_o  (any)
    );

    // next state: grant only in IDLE, then strobe, wait for busy, wait for done, optional gap
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        tx_data_d   = tx_data_q;
        grant_id_d  = grant_id_q;
        err_d       = err_q;
        tx_start_d  = 1'b0;
        req_ready_o = '0;
        case (state_q)
            IDLE: begin
                req_ready_o = gnt;
                if (any) begin
                    state_d    = START;
                    last_d     = win;
                    grant_id_d = win;
                    tx_data_d  = req_data_i[win*DATA_W +: DATA_W];
                    tx_start_d = 1'b1;
                end
            end
            START: begin
                state_d = WAIT_BUSY;
                cnt_d   = '0;
            end
            WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(BUSY_TMO - 1)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_i) begin
                    state_d = GAP_CLKS > 0 ? GAP : IDLE;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CLKS - 1)) state_d = IDLE;
                else cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers; async active-low reset restores requester 0 priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_q     <= IW'(N_REQ - 1);
            cnt_q      <= '0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            tx_start_q <= tx_start_d;
            err_q      <= err_d;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_start_o = tx_start_q;
    assign grant_id_o = grant_id_q;
    assign err_tmo_o  = err_q;
    assign active_o   = state_q != IDLE;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of the UART arbiter against a behavioural model
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start, tx_busy, active, err_tmo;
    logic [1:0]  grant_id;

    logic [1:0]  rv_g = '0;
    logic [15:0] rd_g = '0;
    logic [1:0]  rr_g;
    logic [7:0]  td_g;
    logic        ts_g, tb_g, act_g, err_g;
    logic [0:0]  gid_g;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_len = 5;
    int busy_left = 0;
    int bl_g = 0;
    bit ser_en = 1'b1;
    int model_last = 3;
    int acc_cyc = 0;

    localparam int GAP_G = 234;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(req_ready), .tx_data_o(tx_data), .tx_start_o(tx_start),
        .tx_busy_i(tx_busy), .grant_id_o(grant_id), .active_o(active), .err_tmo_o(err_tmo)
    );

    uart_tx_arbiter #(.N_REQ(2), .GAP_CLKS(GAP_G)) dut_g (
        .clk(clk), .rst(rst), .req_valid_i(rv_g), .req_data_i(rd_g),
        .req_ready_o(rr_g), .tx_data_o(td_g), .tx_start_o(ts_g),
        .tx_busy_i(tb_g), .grant_id_o(gid_g), .active_o(act_g), .err_tmo_o(err_g)
    );

    // serializer model: busy from the cycle after the start strobe for busy_len cycles
    always @(posedge clk or negedge rst) begin
        if (!rst) busy_left <= 0;
        else if (tx_start && ser_en) busy_left <= busy_len;
        else if (busy_left > 0) busy_left <= busy_left - 1;
    end
    assign tx_busy = busy_left > 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) bl_g <= 0;
        else if (ts_g) bl_g <= 10;
        else if (bl_g > 0) bl_g <= bl_g - 1;
    end
    assign tb_g = bl_g > 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    // offer v/d, wait for the grant, check it against the model and the following strobe
    task automatic serve(input logic [3:0] v, input logic [31:0] d);
        int w;
        bit found;
        found = 1'b0;
        req_valid = v;
        req_data = d;
        for (int i = 0; i < 6000 && !found; i++) begin
            #1;
            if (|(req_ready & req_valid)) found = 1'b1;
            else @(negedge clk);
        end
        chk("accept_wait", 32'(found), 1);
        if (!found) return;
        w = pick(v, model_last);
        chk("req_ready", 32'(req_ready), 32'(1) << w);
        chk("active_idle", 32'(active), 0);
        acc_cyc = cyc;
        model_last = w;
        @(negedge clk);
        chk("tx_start", 32'(tx_start), 1);
        chk("tx_data", 32'(tx_data), 32'(d[w*8 +: 8]));
        chk("grant_id", 32'(grant_id), w);
        chk("active_start", 32'(active), 1);
        @(negedge clk);
        chk("tx_start_once", 32'(tx_start), 0);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 6000 && !ok; i++) begin
            @(negedge clk);
            ok = !active;
        end
        chk("idle_wait", 32'(ok), 1);
    endtask

    initial begin
        int a1, d_cyc;
        bit ok;
        logic [3:0] v;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_err", 32'(err_tmo), 0);
        chk("rst_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst = 1'b1;

        busy_len = 2345;
        serve(4'b1111, 32'h44434241);
        a1 = acc_cyc;
        serve(4'b1111, 32'h44434241);
        chk("spacing", acc_cyc - a1, 2345 + 3);
        serve(4'b1111, 32'h44434241);
        serve(4'b1111, 32'h44434241);
        serve(4'b1111, 32'h44434241);
        chk("wrap_grant0", 32'(grant_id), 0);
        req_valid = '0;
        wait_idle();

        busy_len = 20;
        serve(4'b0100, 32'h00550000);
        req_valid = '0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            ok = !tx_busy;
            if (!ok) @(negedge clk);
        end
        chk("busy_fall_seen", 32'(ok), 1);
        chk("active_at_fall", 32'(active), 1);
        @(negedge clk);
        chk("active_after", 32'(active), 0);

        serve(4'b0010, 32'h00006600);
        req_valid = '0;
        wait_idle();
        serve(4'b0011, 32'h00007711);
        chk("rr_wrap_to0", 32'(grant_id), 0);
        req_valid = '0;

        for (int n = 0; n < 30; n++) begin
            busy_len = int'($urandom_range(1, 30));
            v = 4'($urandom_range(1, 15));
            serve(v, $urandom);
            if ($urandom_range(0, 1) == 1) req_valid = '0;
        end
        req_valid = '0;
        wait_idle();
        chk("no_err_yet", 32'(err_tmo), 0);

        ser_en = 1'b0;
        serve(4'b0001, 32'h000000a5);
        req_valid = '0;
        chk("tmo_e0", 32'(err_tmo), 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("tmo_early", 32'(err_tmo), 0);
        end
        @(negedge clk);
        chk("tmo_set", 32'(err_tmo), 1);
        chk("tmo_idle", 32'(active), 0);
        ser_en = 1'b1;
        busy_len = 8;
        serve(4'b0010, 32'h00003c00);
        chk("tmo_sticky", 32'(err_tmo), 1);
        req_valid = '0;
        wait_idle();

        busy_len = 100;
        serve(4'b0100, 32'h00990000);
        req_valid = '0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_tx_data", 32'(tx_data), 0);
        chk("mid_tx_start", 32'(tx_start), 0);
        chk("mid_grant", 32'(grant_id), 0);
        chk("mid_active", 32'(active), 0);
        chk("mid_err", 32'(err_tmo), 0);
        chk("mid_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        model_last = 3;
        busy_len = 5;
        serve(4'b1001, 32'hd0000011);
        chk("post_rst_win0", 32'(grant_id), 0);
        req_valid = '0;

        rv_g = 2'b01;
        rd_g = 16'h0077;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = tb_g;
        end
        chk("gap_busy_seen", 32'(ok), 1);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = !tb_g;
        end
        d_cyc = cyc;
        chk("gap_no_ready_fall", 32'(rr_g), 0);
        chk("gap_active", 32'(act_g), 1);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = |rr_g;
        end
        chk("gap_ready_seen", 32'(ok), 1);
        chk("gap_len", cyc - d_cyc, GAP_G + 1);
        rv_g = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
